// File: rtl/uart_rx_ctrl.sv
// UART receiver front-end: oversample tick generator, parity mode latch, and a
// show-ahead capture FIFO with overrun and error statistics.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          rx_enable,
    input  logic                          parity_enable_cfg,
    input  logic                          flush,
    input  logic                          clear_overrun,
    output logic                          tick_16x,
    output logic                          parity_enable,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          data_ready,
    input  logic                          parity_err,
    input  logic                          frame_err,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic [7:0]                    err_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 2;

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 tick_q, tick_d;
    logic                 par_en_q, par_en_d;
    logic                 dr_q, dr_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 m_valid_q, m_valid_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic push_req, full, pop, do_push, do_pop, drop, has_err;

    // Host handshake: the head entry is transferred on any cycle where
    // m_valid && m_ready; m_valid never depends on m_ready.
    always_comb begin
        push_req = data_ready && !dr_q && rx_enable;
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = m_valid_q && m_ready;
        has_err  = parity_err || frame_err;
        do_push  = push_req && (!full || pop) && !flush;
        do_pop   = pop && !flush;
        drop     = push_req && full && !pop && !flush;

        div_cnt_d = '0;
        tick_d    = 1'b0;
        if (rx_enable) begin
            if (div_cnt_q >= baud_div) begin
                tick_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
        end

        par_en_d = rx_enable ? par_en_q : parity_enable_cfg;
        dr_d     = data_ready;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {frame_err, parity_err, rx_data};
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
        m_valid_d = (count_d != '0);

        // A new drop outranks a simultaneous clear.
        overrun_d = drop ? 1'b1 : (clear_overrun ? 1'b0 : overrun_q);

        err_cnt_d = err_cnt_q;
        if (push_req && has_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            par_en_q  <= 1'b0;
            dr_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            par_en_q  <= par_en_d;
            dr_q      <= dr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tick_16x      = tick_q;
    assign parity_enable = par_en_q;
    assign m_data        = mem_q[rd_ptr_q][DATA_BITS-1:0];
    assign m_perr        = mem_q[rd_ptr_q][DATA_BITS];
    assign m_ferr        = mem_q[rd_ptr_q][DATA_BITS+1];
    assign m_valid       = m_valid_q;
    assign fifo_count    = count_q;
    assign overrun       = overrun_q;
    assign err_count     = err_cnt_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control and buffering front-end for the UART receiver.
- Generates the receiver's oversample tick from a programmable divisor.
- Owns the receiver's parity configuration.
- Captures each received word and its error flags into a small show-ahead FIFO, presented to the host with a valid/ready handshake.
- Tracks overrun and error statistics.
- Sits between the UART receiver and the host/bus register interface.

Parameters:
- DATA_BITS, 8, received word width; must match the receiver's DATA_BITS.
- FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- baud_div  input  DIV_WIDTH  tick period minus one, in clk cycles.
- rx_enable  input  1  enables tick generation and capture.
- parity_enable_cfg  input  1  requested parity mode.
- flush  input  1  single-cycle pulse; empties the FIFO.
- clear_overrun  input  1  single-cycle pulse; clears the overrun flag.
- tick_16x  output  1  oversample strobe to the receiver.
- parity_enable  output  1  parity mode to the receiver.
- rx_data  input  DATA_BITS  word from the receiver.
- data_ready  input  1  receiver word-complete flag; level, held for one tick period.
- parity_err  input  1  receiver parity error.
- frame_err  input  1  receiver framing error.
- m_data  output  DATA_BITS  FIFO head word.
- m_perr  output  1  FIFO head parity error.
- m_ferr  output  1  FIFO head framing error.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  host accepts the head entry.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of valid entries.
- overrun  output  1  sticky; a word was dropped because the FIFO was full.
- err_count  output  8  saturating count of words with any error.

Behaviour:
- Reset (reset=0, asynchronous) drives the following to 0:
  - tick_16x, parity_enable, m_valid, fifo_count, overrun, err_count;
  - FIFO storage, pointers, divider counter and the data_ready edge register.
  - After reset, m_data, m_perr and m_ferr read 0.
- Tick generator:
  - Counter div_cnt runs only while rx_enable=1.
  - When div_cnt >= baud_div: tick_16x=1 for exactly that cycle and div_cnt<=0; otherwise div_cnt increments.
  - The tick period is therefore baud_div+1 cycles; baud_div=0 gives a tick every cycle.
  - A divisor change takes effect immediately. The >= compare means a reduced divisor never waits for wrap-around.
  - rx_enable=0: div_cnt<=0 and tick_16x=0 (registered output).
- Parity configuration:
  - parity_enable loads parity_enable_cfg every cycle while rx_enable=0.
  - It is frozen while rx_enable=1, so the mode never changes mid-frame.
- Capture:
  - dr_q registers data_ready every cycle.
  - A push is requested when data_ready=1 && dr_q=0 && rx_enable=1. This gives exactly one push per received word, regardless of how long data_ready is held.
  - Push writes {frame_err, parity_err, rx_data}, sampled in the same cycle.
- FIFO:
  - Show-ahead: m_data, m_perr and m_ferr show the head entry combinationally from storage.
  - m_valid = fifo_count != 0.
  - Pop occurs when m_valid && m_ready.
  - Push when not full: accepted.
  - Push when full with a simultaneous pop: accepted; count unchanged; no overrun.
  - Push when full without a pop: word dropped, overrun<=1.
  - Push and pop when empty: push only (no pop, because m_valid=0).
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count increments on push-only, decrements on pop-only, and is unchanged for both or neither.
- Flush:
  - Pointers and count go to 0 the next cycle.
  - Any push or pop in the same cycle is discarded.
  - A discarded push still counts toward err_count if it carries an error.
  - overrun is not affected.
- Overrun flag:
  - Sticky; cleared by clear_overrun.
  - If a new overrun occurs in the same cycle as clear_overrun, set wins.
- Error counter:
  - Increments by 1 for every capture (accepted, dropped or flushed) with parity_err|frame_err.
  - Saturates at 255.
  - Cleared only by reset.
- Disabling rx_enable mid-frame:
  - Tick stops, so the receiver freezes.
  - FIFO contents and statistics are retained.
  - A data_ready rising edge while disabled is ignored. dr_q still tracks, so re-enabling with data_ready held high causes no push.
- All outputs except m_data, m_perr and m_ferr are registered.

Test Plan:
- Tick generation: reset released, rx_enable=1, baud_div=3 -> tick_16x high one cycle in every 4; baud_div=0 -> high every cycle; rx_enable=0 -> tick_16x=0 the next cycle.
- Capture and handshake: data_ready pulse held 4 cycles with rx_data=0x5A, errors 0 -> exactly one entry; m_valid=1, m_data=0x5A, fifo_count=1; m_ready=1 for one cycle -> m_valid=0, fifo_count=0.
- FIFO full and overrun: push 0x01..0x04 with m_ready=0 -> fifo_count=4; push 0x05 -> dropped, overrun=1; pops then return 0x01..0x04 in order.
- Full with simultaneous push and pop: FIFO holds 0x01..0x04, push 0x05 with m_ready=1 -> fifo_count stays 4, overrun=0; drain returns 0x02..0x05.
- Errors and saturation: 3 words with frame_err=1 -> err_count=3 and the head shows m_ferr=1; 260 words with parity_err=1 -> err_count=255; clear_overrun coincident with a new overrun -> overrun stays 1.
- Configuration lock and reset: parity_enable_cfg toggled while rx_enable=1 -> parity_enable unchanged; toggled while disabled -> follows next cycle; reset asserted with 2 entries queued -> all outputs 0 asynchronously.
